serial_ripple_subtractor: RTL and testbench
===========================================

// Module: serial_ripple_subtractor
// PURPOSE
//   Bit-serial unsigned subtractor: computes DIFF = A - B - bi one bit per
//   clock, LSB first, through a single full-subtractor stage and a borrow flop.
//   It is the inverse arithmetic companion of the combinational ripple adder,
//   and is sized for area-constrained datapaths that can tolerate WIDTH-cycle
//   latency. Operands are taken in, and results handed out, over valid/ready
//   handshakes.
// PARAMETERS
//   WIDTH  4  operand/result width in bits; legal range 1..32
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      A, B, bi valid
//   in_ready   out  1      block can accept operands (high only in IDLE)
//   A          in   WIDTH  minuend (unsigned)
//   B          in   WIDTH  subtrahend (unsigned)
//   bi         in   1      borrow-in
//   out_valid  out  1      DIFF and bo valid
//   out_ready  in   1      consumer accepts result
//   DIFF       out  WIDTH  difference, modulo 2^WIDTH
//   bo         out  1      borrow-out; 1 iff A < B + bi
//   busy       out  1      high in RUN or DONE
// BEHAVIOUR
// - Reset (async assert; deassertion sampled on clk): state=IDLE.
//   Reset values: in_ready=1, out_valid=0, busy=0, DIFF=0, bo=0.
//   Internal operand registers, bit counter and borrow flop are cleared.
// - FSM states: IDLE, RUN, DONE.
// - IDLE: in_ready=1.
//   - On an edge with in_valid=1: latch A, B; set borrow flop=bi, counter=0, DIFF=0, bo=0.
//   - Go to RUN.
// - RUN: in_ready=0, busy=1; in_valid is ignored. Each edge does:
//   - d_i    = a_i ^ b_i ^ brw
//   - brw'   = (~a_i & b_i) | (~a_i & brw) | (b_i & brw)
//   - Shift d_i into DIFF bit position `counter`, then increment the counter.
//   - On the edge that processes bit WIDTH-1: bo takes the final brw', and the
//     state goes to DONE.
// - Latency: the accept edge is E0. Bits are computed on edges E1..EWIDTH, and
//   out_valid rises after EWIDTH, i.e. WIDTH cycles after the accept edge.
// - DONE: out_valid=1, busy=1, in_ready=0. DIFF and bo are held stable while
//   out_ready=0 (no limit on backpressure duration).
//   - On an edge with out_ready=1: go to IDLE, out_valid=0.
//   - DIFF and bo keep their values until the next accept.
// - No overlap: a new operand set can be accepted at the earliest one cycle
//   after the result handshake. Sustained throughput is 1 op per WIDTH+2 cycles.
// - Width rules: all arithmetic is unsigned modulo 2^WIDTH.
//   - bo=1 exactly when the true difference is negative.
//   - {bo,DIFF} equals the WIDTH+1-bit two's-complement result of A - B - bi.
// - WIDTH=1: RUN lasts exactly one cycle; the counter is 1 bit wide and must not wrap early.
// - Reset mid-operation (RUN or DONE): the operation is discarded and all
//   outputs return to reset values immediately (asynchronously).
// - X on in_valid or out_ready is illegal. A, B and bi are don't-care unless
//   in_valid=1 in IDLE.
// TESTING
// - WIDTH=4. A=9, B=3, bi=0 -> out_valid exactly 4 cycles after accept;
//   DIFF=6, bo=0.
// - A=3, B=9, bi=0 -> DIFF=4'hA, bo=1. A=0, B=0, bi=1 -> DIFF=4'hF, bo=1.
//   A=F, B=F, bi=0 -> DIFF=0, bo=0.
// - Backpressure: hold out_ready=0 for 5 cycles in DONE. DIFF and bo stay
//   stable, in_ready stays 0, and in_valid pulses are ignored. Raising
//   out_ready gives in_ready=1 on the next cycle.
// - Assert rst_n=0 in the cycle after bit 1 is processed -> out_valid=0,
//   DIFF=0, bo=0, busy=0, in_ready=1 immediately. Then A=5, B=2 -> DIFF=3, bo=0.
// - Random 2000 ops, WIDTH in {1,4,8}, random in_valid/out_ready stalls.
//   Scoreboard checks {bo,DIFF}==(A-B-bi) and the latency: out_valid exactly
//   WIDTH cycles after the accept edge, with no dropped or duplicated results.

Source files
------------

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor stage plus a borrow flop,
// LSB first, with valid/ready handshakes on the operand and result sides.
module serial_ripple_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] DIFF,
    output logic             bo,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] diff_r;
    logic [CW-1:0]    cnt_r;
    logic             brw_r;
    logic             bo_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;
    logic             d_s;
    logic             brw_nxt_s;

    // Returns {borrow_out, difference} of a single-bit full subtractor.
    function automatic logic [1:0] full_sub(input logic a_bit, input logic b_bit, input logic c_bit);
        full_sub = {(~a_bit & b_bit) | (~a_bit & c_bit) | (b_bit & c_bit), a_bit ^ b_bit ^ c_bit};
    endfunction

    // Current bit slice through the subtractor stage; forced quiet outside RUN.
    always_comb begin
        {brw_nxt_s, d_s} = 2'b00;
        if (state_r == RUN) begin
            {brw_nxt_s, d_s} = full_sub(a_r[cnt_r], b_r[cnt_r], brw_r);
        end else begin
            {brw_nxt_s, d_s} = 2'b00;
        end
    end

    // Control FSM, operand/borrow state and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            diff_r      <= '0;
            cnt_r       <= '0;
            brw_r       <= 1'b0;
            bo_r        <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r        <= A;
                        b_r        <= B;
                        brw_r      <= bi;
                        cnt_r      <= '0;
                        diff_r     <= '0;
                        bo_r       <= 1'b0;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    diff_r[cnt_r] <= d_s;
                    brw_r         <= brw_nxt_s;
                    if (cnt_r == LAST_BIT) begin
                        bo_r        <= brw_nxt_s;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= '0;
                    brw_r       <= 1'b0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign DIFF      = diff_r;
    assign bo        = bo_r;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Bench for serial_ripple_subtractor: directed WIDTH=4 cases plus randomized
// scoreboarded traffic on WIDTH 1, 4 and 8 instances.
module tb_serial_ripple_subtractor;

    localparam int N_OPS = 667;

    logic clk = 1'b0;
    logic rst_n_d;
    logic rst_n_r;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // ---------------- directed WIDTH=4 instance ----------------
    logic       d_iv   = 1'b0;
    logic       d_ordy = 1'b0;
    logic       d_bi   = 1'b0;
    logic [3:0] d_a    = 4'h0;
    logic [3:0] d_b    = 4'h0;
    logic       d_ir;
    logic       d_ov;
    logic       d_bo;
    logic       d_busy;
    logic [3:0] d_diff;

    typedef struct {
        logic [4:0] exp;
        int         acc;
    } dent_t;
    dent_t dq[$];

    serial_ripple_subtractor #(.WIDTH(4)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n_d),
        .in_valid (d_iv),
        .in_ready (d_ir),
        .A        (d_a),
        .B        (d_b),
        .bi       (d_bi),
        .out_valid(d_ov),
        .out_ready(d_ordy),
        .DIFF     (d_diff),
        .bo       (d_bo),
        .busy     (d_busy)
    );

    task automatic accept_op(input logic [3:0] a, input logic [3:0] b, input logic bi_v);
        int n = 0;
        @(negedge clk);
        while (!d_ir && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("dir_in_ready", {63'd0, d_ir}, 64'd1);
        d_iv = 1'b1;
        d_a  = a;
        d_b  = b;
        d_bi = bi_v;
        dq.push_back('{exp: ({1'b0, a} - {1'b0, b} - {4'b0000, bi_v}), acc: cyc + 1});
        @(negedge clk);
        d_iv = 1'b0;
    endtask

    task automatic finish_op(input int stall);
        int    n = 0;
        dent_t e;
        while (!d_ov && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("dir_out_valid", {63'd0, d_ov}, 64'd1);
        e = dq.pop_front();
        check("dir_latency", 64'(cyc - e.acc), 64'd4);
        check("dir_result", {59'd0, d_bo, d_diff}, {59'd0, e.exp});
        check("dir_busy_ready", {62'd0, d_busy, d_ir}, 64'd2);
        for (int i = 0; i < stall; i++) begin
            d_iv   = 1'b1;
            d_a    = 4'($urandom);
            d_b    = 4'($urandom);
            d_ordy = 1'b0;
            @(negedge clk);
            check("bp_hold", {57'd0, d_ov, d_ir, d_bo, d_diff}, {57'd0, 1'b1, 1'b0, e.exp});
        end
        d_iv   = 1'b0;
        d_ordy = 1'b1;
        @(negedge clk);
        d_ordy = 1'b0;
        check("handshake_flags", {61'd0, d_ov, d_ir, d_busy}, 64'd2);
        check("held_after_handshake", {59'd0, d_bo, d_diff}, {59'd0, e.exp});
    endtask

    // ---------------- randomized instances, WIDTH 1/4/8 ----------------
    for (genvar gi = 0; gi < 3; gi++) begin : g_rnd
        localparam int W = (gi == 0) ? 1 : ((gi == 1) ? 4 : 8);

        typedef struct {
            logic [W:0] exp;
            int         acc;
        } ent_t;

        logic         iv      = 1'b0;
        logic         ordy    = 1'b0;
        logic         bi_v    = 1'b0;
        logic [W-1:0] a       = '0;
        logic [W-1:0] b       = '0;
        logic         ir;
        logic         ov;
        logic         bo_o;
        logic         bsy;
        logic [W-1:0] d;
        ent_t         q[$];
        int           sent    = 0;
        bit           fin     = 1'b0;
        logic         prev_ov = 1'b0;

        serial_ripple_subtractor #(.WIDTH(W)) u_rnd (
            .clk      (clk),
            .rst_n    (rst_n_r),
            .in_valid (iv),
            .in_ready (ir),
            .A        (a),
            .B        (b),
            .bi       (bi_v),
            .out_valid(ov),
            .out_ready(ordy),
            .DIFF     (d),
            .bo       (bo_o),
            .busy     (bsy)
        );

        always @(negedge clk) begin
            if (rst_n_r) begin
                if (ov) begin
                    if (q.size() == 0) begin
                        check("rnd_unexpected_result", 64'd1, 64'd0);
                    end else if (!prev_ov) begin
                        check("rnd_latency", 64'(cyc - q[0].acc), 64'(W));
                        check("rnd_result", 64'({bo_o, d}), 64'(q[0].exp));
                    end else begin
                        check("rnd_stable", 64'({bo_o, d}), 64'(q[0].exp));
                    end
                end
                prev_ov = ov;
                ordy = ($urandom_range(0, 3) != 0);
                if (ov && ordy && q.size() != 0) begin
                    void'(q.pop_front());
                end
                a    = W'($urandom);
                b    = W'($urandom);
                bi_v = 1'($urandom);
                if (sent < N_OPS && $urandom_range(0, 2) != 0) begin
                    iv = 1'b1;
                    if (ir) begin
                        q.push_back('{exp: ({1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi_v}), acc: cyc + 1});
                        sent++;
                    end
                end else begin
                    iv = 1'b0;
                end
                fin = (sent == N_OPS) && (q.size() == 0);
            end
        end
    end

    initial begin
        int n = 0;
        rst_n_d = 1'b0;
        rst_n_r = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {56'd0, d_ir, d_ov, d_busy, d_bo, d_diff}, {56'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0});
        rst_n_d = 1'b1;
        rst_n_r = 1'b1;

        accept_op(4'd9, 4'd3, 1'b0);
        finish_op(5);
        accept_op(4'd3, 4'd9, 1'b0);
        finish_op(0);
        accept_op(4'd0, 4'd0, 1'b1);
        finish_op(1);
        accept_op(4'hF, 4'hF, 1'b0);
        finish_op(0);
        accept_op(4'hF, 4'h0, 1'b1);
        finish_op(2);

        accept_op(4'd7, 4'd2, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n_d = 1'b0;
        #1;
        check("reset_mid_op", {56'd0, d_ir, d_ov, d_busy, d_bo, d_diff}, {56'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0});
        dq.delete();
        @(negedge clk);
        rst_n_d = 1'b1;
        accept_op(4'd5, 4'd2, 1'b0);
        finish_op(0);

        while (!(g_rnd[0].fin && g_rnd[1].fin && g_rnd[2].fin) && n < 60000) begin
            @(negedge clk);
            n++;
        end
        check("rnd_all_complete", {63'd0, (g_rnd[0].fin && g_rnd[1].fin && g_rnd[2].fin)}, 64'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
